// File: rtl/codec_config_sequencer.sv
// Walks an 11-entry codec register table, issuing one I2C write per entry through
// a start/communicating handshake with the slow-clock I2C driver.
module codec_config_sequencer #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h1A,
  parameter int         POWERUP_CYCLES = 50000,
  parameter int         GAP_CYCLES     = 2048,
  parameter int         TIMEOUT_CYCLES = 200000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       go,
  output logic       i2c_start,
  input  logic       i2c_communicating,
  output logic [6:0] SlaveAddress,
  output logic [7:0] RegisterAddress,
  output logic [7:0] dataSend,
  output logic       write,
  output logic       read,
  output logic [3:0] index,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE, S_POWERUP, S_ISSUE, S_WAIT_ACCEPT, S_WAIT_DONE, S_GAP, S_DONE, S_ERROR
  } state_t;

  localparam logic [31:0] PU_LAST  = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  LAST_IDX = 4'd10;

  state_t      state;
  logic [31:0] cnt;
  logic        comm_p0, comm_p1;
  logic        comm_s;
  logic [15:0] entry;

  // Entry layout: {reg[6:0], data[8:0]}
  function automatic logic [15:0] table_entry(input logic [3:0] i);
    case (i)
      4'd0:    table_entry = {7'h0F, 9'h000};
      4'd1:    table_entry = {7'h06, 9'h000};
      4'd2:    table_entry = {7'h00, 9'h017};
      4'd3:    table_entry = {7'h01, 9'h017};
      4'd4:    table_entry = {7'h02, 9'h179};
      4'd5:    table_entry = {7'h03, 9'h079};
      4'd6:    table_entry = {7'h04, 9'h012};
      4'd7:    table_entry = {7'h05, 9'h000};
      4'd8:    table_entry = {7'h07, 9'h042};
      4'd9:    table_entry = {7'h08, 9'h000};
      4'd10:   table_entry = {7'h09, 9'h001};
      default: table_entry = {7'h0F, 9'h000};
    endcase
  endfunction

  assign entry        = table_entry(index);
  assign comm_s       = comm_p1;
  assign SlaveAddress = SLAVE_ADDR;
  assign write        = 1'b1;
  assign read         = 1'b0;

  // Two-flop synchronizer for the driver's busy flag (slow-clock domain)
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      comm_p0 <= 1'b0;
      comm_p1 <= 1'b0;
    end else begin
      comm_p0 <= i2c_communicating;
      comm_p1 <= comm_p0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      index           <= '0;
      i2c_start       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      RegisterAddress <= 8'h1E;
      dataSend        <= 8'h00;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (go) begin
            state <= S_POWERUP;
            index <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
          end
        end
        S_POWERUP: begin
          if (cnt == PU_LAST) begin
            state <= S_ISSUE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_ISSUE: begin
          RegisterAddress <= {entry[15:9], entry[8]};
          dataSend        <= entry[7:0];
          i2c_start       <= 1'b1;
          cnt             <= '0;
          state           <= S_WAIT_ACCEPT;
        end
        S_WAIT_ACCEPT: begin
          if (comm_s) begin
            i2c_start <= 1'b0;
            cnt       <= '0;
            state     <= S_WAIT_DONE;
          end else if (cnt == TO_LAST) begin
            i2c_start <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b1;
            state     <= S_ERROR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!comm_s) begin
            cnt <= '0;
            if (index == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_GAP;
            end
          end else if (cnt == TO_LAST) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= S_ERROR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_GAP: begin
          // Index advances only here, and only from entries below the last one
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            index <= index + 4'd1;
            state <= S_ISSUE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: behavioural I2C driver, pass-level reference
// model checked every cycle, plus directed scenarios for timeout, reset and restart.
module tb_codec_config_sequencer;

  localparam int PU  = 20;
  localparam int GAP = 10;
  localparam int TO  = 1000;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0;
  logic       i2c_communicating = 1'b0;
  logic       i2c_start;
  logic [6:0] SlaveAddress;
  logic [7:0] RegisterAddress;
  logic [7:0] dataSend;
  logic       write, read;
  logic [3:0] index;
  logic       busy, done, error;

  codec_config_sequencer #(
    .SLAVE_ADDR(7'h1A), .POWERUP_CYCLES(PU), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .go(go), .i2c_start(i2c_start),
    .i2c_communicating(i2c_communicating), .SlaveAddress(SlaveAddress),
    .RegisterAddress(RegisterAddress), .dataSend(dataSend), .write(write), .read(read),
    .index(index), .busy(busy), .done(done), .error(error)
  );

  initial forever #5 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference table
  int mreg[11] = '{'h0F, 'h06, 'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h07, 'h08, 'h09};
  int mdat[11] = '{'h000, 'h000, 'h017, 'h017, 'h179, 'h079, 'h012, 'h000, 'h042, 'h000, 'h001};

  function automatic int exp_ra(input int i);
    return mreg[i] * 2 + mdat[i] / 256;
  endfunction

  function automatic int exp_ds(input int i);
    return mdat[i] % 256;
  endfunction

  // Behavioural I2C driver
  int acc_dly = 3;
  int busy_len = 40;
  bit rnd = 1'b0;
  bit no_accept = 1'b0;

  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (reset && i2c_start && !no_accept && !i2c_communicating) begin
        int a, b;
        a = rnd ? int'($urandom_range(1, 40)) : acc_dly;
        b = rnd ? int'($urandom_range(8, 60)) : busy_len;
        repeat (a) @(negedge CLOCK_50);
        #1 i2c_communicating = 1'b1;
        repeat (b) @(negedge CLOCK_50);
        #1 i2c_communicating = 1'b0;
      end
    end
  end

  // Pass-level model: phase, transaction count, quiet-cycle and start-hold counters
  typedef enum {M_IDLE, M_RUN, M_DONE, M_ERR} mphase_t;
  mphase_t ph = M_IDLE;
  int  txn = 0;
  int  idle_ctr = 0;
  int  start_hi = 0;
  int  err_idx = 0;
  bit  prev_start = 1'b0;
  int  lat_ra = 0, lat_ds = 0;

  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (!reset) begin
        ph = M_IDLE; txn = 0; idle_ctr = 0; start_hi = 0; err_idx = 0; prev_start = 1'b0;
        continue;
      end
      chk("slave_addr", int'(SlaveAddress), 'h1A);
      chk("write_const", int'(write), 1);
      chk("read_const", int'(read), 0);
      chk("index_le_10", int'(index <= 4'd10), 1);

      if (ph != M_RUN && go) begin
        ph = M_RUN; txn = 0; idle_ctr = 0; start_hi = 0; err_idx = 0;
        chk("go_index0", int'(index), 0);
      end

      if (ph == M_RUN) begin
        if (start_hi == TO) begin
          chk("timeout_error", int'(error), 1);
          chk("timeout_start", int'(i2c_start), 0);
          chk("timeout_busy", int'(busy), 0);
          chk("timeout_index", int'(index), err_idx);
          ph = M_ERR;
          start_hi = 0;
        end else begin
          if (i2c_start && !prev_start) begin
            chk("start_latency", idle_ctr, (txn == 0) ? PU + 1 : GAP + 3);
            chk("txn_in_range", int'(txn < 11), 1);
            if (txn < 11) begin
              chk("txn_index", int'(index), txn);
              chk("txn_reg_addr", int'(RegisterAddress), exp_ra(txn));
              chk("txn_data", int'(dataSend), exp_ds(txn));
            end
            if (txn == 0)  begin chk("e0_ra", int'(RegisterAddress), 'h1E); chk("e0_ds", int'(dataSend), 'h00); end
            if (txn == 4)  begin chk("e4_ra", int'(RegisterAddress), 'h05); chk("e4_ds", int'(dataSend), 'h79); end
            if (txn == 10) begin chk("e10_ra", int'(RegisterAddress), 'h12); chk("e10_ds", int'(dataSend), 'h01); end
            lat_ra = int'(RegisterAddress);
            lat_ds = int'(dataSend);
            err_idx = txn;
            txn++;
          end else if (txn > 0) begin
            chk("addr_stable", int'(RegisterAddress), lat_ra);
            chk("data_stable", int'(dataSend), lat_ds);
            if (i2c_start) chk("index_stable", int'(index), txn - 1);
          end
          if (i2c_start) begin
            start_hi++;
            idle_ctr = 0;
          end else begin
            start_hi = 0;
            idle_ctr = i2c_communicating ? 0 : idle_ctr + 1;
          end
          if (txn == 11 && idle_ctr == 3) begin
            chk("pass_done", int'(done), 1);
            chk("pass_done_busy", int'(busy), 0);
            chk("pass_done_index", int'(index), 10);
            ph = M_DONE;
          end else begin
            chk("run_busy", int'(busy), 1);
            chk("run_done", int'(done), 0);
            chk("run_error", int'(error), 0);
          end
        end
      end else begin
        chk("rest_start", int'(i2c_start), 0);
        chk("rest_busy", int'(busy), 0);
        chk("rest_done", int'(done), int'(ph == M_DONE));
        chk("rest_error", int'(error), int'(ph == M_ERR));
        chk("rest_index", int'(index), (ph == M_DONE) ? 10 : (ph == M_ERR) ? err_idx : 0);
      end
      prev_start = i2c_start;
    end
  end

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_end(input int budget, input bit poke);
    int n;
    n = 0;
    while (!done && !error && n < budget) begin
      go = poke && busy && (index < 4'd9) && ($urandom_range(0, 15) == 0);
      tick();
      n++;
    end
    go = 1'b0;
    chk("pass_end_in_time", int'(n < budget), 1);
  endtask

  task automatic chk_reset_values();
    chk("rst_start", int'(i2c_start), 0);
    chk("rst_index", int'(index), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_reg_addr", int'(RegisterAddress), 'h1E);
    chk("rst_data", int'(dataSend), 'h00);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hold;
    repeat (3) tick();
    chk_reset_values();
    reset = 1'b1;
    repeat (30) tick();
    chk("no_go_idle_busy", int'(busy), 0);
    chk("no_go_idle_start", int'(i2c_start), 0);

    // Basic pass: accept 3 cycles after start, 40 cycles busy
    pulse_go();
    wait_end(5000, 1'b1);
    chk("a_done", int'(done), 1);
    chk("a_error", int'(error), 0);
    chk("a_index", int'(index), 10);
    chk("a_txn_count", txn, 11);

    // Slow acceptance on the first entry
    acc_dly = 500;
    pulse_go();
    n = 0;
    while (!i2c_start && n < 200) begin tick(); n++; end
    chk("slow_start_seen", int'(n < 200), 1);
    acc_dly = 3;
    hold = 0;
    while (i2c_start && hold < 5000) begin hold++; tick(); end
    chk("slow_start_hold", hold, 503);
    wait_end(5000, 1'b1);
    chk("slow_done", int'(done), 1);

    // Driver never accepts: timeout then recovery
    no_accept = 1'b1;
    pulse_go();
    wait_end(3000, 1'b0);
    chk("to_error", int'(error), 1);
    chk("to_done", int'(done), 0);
    chk("to_index", int'(index), 0);
    chk("to_start", int'(i2c_start), 0);
    no_accept = 1'b0;
    pulse_go();
    chk("to_recover_error", int'(error), 0);
    chk("to_recover_busy", int'(busy), 1);
    wait_end(5000, 1'b1);
    chk("to_recover_done", int'(done), 1);

    // Reset in the middle of entry 6
    pulse_go();
    n = 0;
    while (!(index == 4'd6 && !i2c_start && i2c_communicating) && n < 3000) begin tick(); n++; end
    chk("e6_wait_done_seen", int'(n < 3000), 1);
    reset = 1'b0;
    #1;
    chk_reset_values();
    repeat (3) tick();
    reset = 1'b1;
    n = 0;
    while (i2c_communicating && n < 200) begin tick(); n++; end
    repeat (30) tick();
    chk("post_rst_idle_busy", int'(busy), 0);
    chk("post_rst_idle_start", int'(i2c_start), 0);
    pulse_go();
    n = 0;
    while (!i2c_start && n < 200) begin tick(); n++; end
    chk("post_rst_index", int'(index), 0);
    chk("post_rst_reg_addr", int'(RegisterAddress), 'h1E);
    wait_end(5000, 1'b1);
    chk("post_rst_done", int'(done), 1);

    // go held high: one pass, then immediate restart from DONE
    go = 1'b1;
    n = 0;
    while (!done && n < 5000) begin tick(); n++; end
    chk("held_done", int'(done), 1);
    tick();
    chk("held_restart_busy", int'(busy), 1);
    chk("held_restart_done", int'(done), 0);
    chk("held_restart_index", int'(index), 0);
    go = 1'b0;
    wait_end(5000, 1'b1);
    chk("held_second_done", int'(done), 1);

    // Randomized driver timing with stray go pulses while busy
    rnd = 1'b1;
    for (int p = 0; p < 3; p++) begin
      repeat ($urandom_range(1, 20)) tick();
      pulse_go();
      wait_end(8000, 1'b1);
      chk("rnd_done", int'(done), 1);
      chk("rnd_error", int'(error), 0);
      chk("rnd_index", int'(index), 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
